// File: rtl/sm83_alu_serial.sv
// Slice-serial SM83 ALU: processes DATA_WIDTH-bit operands SLICE_WIDTH bits per clock, LSB first,
// and reports the registered result together with the SM83 Z/N/H/C flags.
module sm83_alu_serial #(
    parameter int DATA_WIDTH  = 8,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_h,
    output logic                  flag_c,
    output logic                  busy,
    output logic                  done
);

    localparam int NSLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    // Bit 3 is always the top bit of this slice because SLICE_WIDTH divides 4.
    localparam int H_SLICE = 3 / SLICE_WIDTH;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    generate
        if (!(SLICE_WIDTH == 1 || SLICE_WIDTH == 2 || SLICE_WIDTH == 4) ||
            (DATA_WIDTH % SLICE_WIDTH) != 0 || DATA_WIDTH < 8) begin : g_bad_params
            $error("sm83_alu_serial: unsupported DATA_WIDTH/SLICE_WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]          r_k;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_a_sh;
    logic [DATA_WIDTH-1:0]  r_b_sh;
    logic [DATA_WIDTH-1:0]  r_shadow;
    logic [2:0]             r_op;
    logic                   r_c;
    logic                   r_h;

    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_z;
    logic                   r_n;
    logic                   r_hf;
    logic                   r_cf;

    logic                   w_accept;
    logic                   w_last;
    logic [SLICE_WIDTH-1:0] w_a_s;
    logic [SLICE_WIDTH-1:0] w_b_s;
    logic [SLICE_WIDTH:0]   w_sum;
    logic                   w_cout;
    logic [SLICE_WIDTH-1:0] w_slice;
    logic [DATA_WIDTH-1:0]  w_shadow_nx;
    logic [3:0]             w_flags;

    function automatic logic is_sub(input logic [2:0] o);
        return (o == OP_SUB) || (o == OP_SBC) || (o == OP_CP);
    endfunction

    // Carry seeded into slice 0; subtraction is A + ~B + 1 (or + !C for SBC).
    function automatic logic slice0_cin(input logic [2:0] o, input logic ci);
        case (o)
            OP_ADC:        return ci;
            OP_SUB, OP_CP: return 1'b1;
            OP_SBC:        return ~ci;
            default:       return 1'b0;
        endcase
    endfunction

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_k == CW'(NSLICES - 1));

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_k <= '0;
        end else if (w_accept) begin
            r_k <= '0;
        end else if (r_state == S_RUN) begin
            r_k <= r_k + 1'b1;
        end
    end

    // Slice datapath: low slice of the shifted operands, ripple carry held in r_c.
    assign w_a_s  = r_a_sh[SLICE_WIDTH-1:0];
    assign w_b_s  = r_b_sh[SLICE_WIDTH-1:0] ^ {SLICE_WIDTH{is_sub(r_op)}};
    assign w_sum  = {1'b0, w_a_s} + {1'b0, w_b_s} + {{SLICE_WIDTH{1'b0}}, r_c};
    assign w_cout = w_sum[SLICE_WIDTH];

    always_comb begin
        w_slice = w_sum[SLICE_WIDTH-1:0];
        case (r_op)
            OP_AND:  w_slice = w_a_s & w_b_s;
            OP_XOR:  w_slice = w_a_s ^ w_b_s;
            OP_OR:   w_slice = w_a_s | w_b_s;
            default: w_slice = w_sum[SLICE_WIDTH-1:0];
        endcase
    end

    assign w_shadow_nx = {w_slice, r_shadow[DATA_WIDTH-1:SLICE_WIDTH]};

    // Operand capture and per-slice shifting; data registers need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a    <= a;
            r_a_sh <= a;
            r_b_sh <= b;
            r_op   <= op;
            r_c    <= slice0_cin(op, carry_in);
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> SLICE_WIDTH;
            r_b_sh   <= r_b_sh >> SLICE_WIDTH;
            r_shadow <= w_shadow_nx;
            r_c      <= w_cout;
            if (r_k == CW'(H_SLICE)) begin
                r_h <= w_cout;
            end
        end
    end

    // Flags as {Z, N, H, C}; subtract ops report borrow, i.e. inverted carries.
    always_comb begin
        w_flags    = 4'b0000;
        w_flags[3] = (w_shadow_nx == '0);
        case (r_op)
            OP_ADD, OP_ADC: begin
                w_flags[1] = r_h;
                w_flags[0] = w_cout;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                w_flags[2] = 1'b1;
                w_flags[1] = ~r_h;
                w_flags[0] = ~w_cout;
            end
            OP_AND:  w_flags[1] = 1'b1;
            default: begin
                w_flags[1] = 1'b0;
                w_flags[0] = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_hf     <= 1'b0;
            r_cf     <= 1'b0;
        end else if (w_last) begin
            r_result <= (r_op == OP_CP) ? r_a : w_shadow_nx;
            r_z      <= w_flags[3];
            r_n      <= w_flags[2];
            r_hf     <= w_flags[1];
            r_cf     <= w_flags[0];
        end
    end

    assign result = r_result;
    assign flag_z = r_z;
    assign flag_n = r_n;
    assign flag_h = r_hf;
    assign flag_c = r_cf;

endmodule

// File: tb/tb_sm83_alu_serial.sv
// Bench for sm83_alu_serial: three instances (8/4, 16/4, 16/1) share the stimulus and are
// compared against an arithmetic reference model of the SM83 ALU rules.
module tb_sm83_alu_serial;

    logic        clk;
    logic        nreset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;

    logic [7:0]  res8;
    logic [15:0] res16;
    logic [15:0] res16s;
    logic [2:0]  fz, fn, fh, fc, bsy, dn;

    logic [15:0] o_res [3];
    logic [3:0]  o_fl  [3];

    int n_cmp = 0;
    int n_err = 0;
    int wid [3] = '{8, 16, 16};
    int lat_exp [3] = '{3, 5, 17};

    sm83_alu_serial #(.DATA_WIDTH(8), .SLICE_WIDTH(4)) dut8 (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
        .carry_in(carry_in), .result(res8), .flag_z(fz[0]), .flag_n(fn[0]), .flag_h(fh[0]),
        .flag_c(fc[0]), .busy(bsy[0]), .done(dn[0]));

    sm83_alu_serial #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) dut16 (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .a(a), .b(b),
        .carry_in(carry_in), .result(res16), .flag_z(fz[1]), .flag_n(fn[1]), .flag_h(fh[1]),
        .flag_c(fc[1]), .busy(bsy[1]), .done(dn[1]));

    sm83_alu_serial #(.DATA_WIDTH(16), .SLICE_WIDTH(1)) dut16s (
        .clk(clk), .nreset(nreset), .start(start), .op(op), .a(a), .b(b),
        .carry_in(carry_in), .result(res16s), .flag_z(fz[2]), .flag_n(fn[2]), .flag_h(fh[2]),
        .flag_c(fc[2]), .busy(bsy[2]), .done(dn[2]));

    assign o_res[0] = {8'h00, res8};
    assign o_res[1] = res16;
    assign o_res[2] = res16s;
    assign o_fl[0]  = {fz[0], fn[0], fh[0], fc[0]};
    assign o_fl[1]  = {fz[1], fn[1], fh[1], fc[1]};
    assign o_fl[2]  = {fz[2], fn[2], fh[2], fc[2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {Z, N, H, C, result[15:0]} computed with plain integer arithmetic.
    function automatic logic [19:0] model(input int w, input logic [2:0] o,
                                          input logic [15:0] va, input logic [15:0] vb,
                                          input logic ci);
        int m, x, y, cc, r;
        logic z, n, h, c;
        logic [15:0] rv;
        m = (1 << w) - 1;
        x = int'(va) & m;
        y = int'(vb) & m;
        cc = 0; r = 0; n = 1'b0; h = 1'b0; c = 1'b0;
        case (o)
            3'd0, 3'd1: begin
                cc = (o == 3'd1) ? int'(ci) : 0;
                r  = x + y + cc;
                h  = ((x & 15) + (y & 15) + cc) > 15;
                c  = r > m;
            end
            3'd2, 3'd3, 3'd7: begin
                cc = (o == 3'd3) ? int'(ci) : 0;
                r  = x - y - cc;
                n  = 1'b1;
                h  = (x & 15) < ((y & 15) + cc);
                c  = x < (y + cc);
            end
            3'd4: begin r = x & y; h = 1'b1; end
            3'd5: r = x ^ y;
            default: r = x | y;
        endcase
        r  = r & m;
        z  = (r == 0);
        rv = (o == 3'd7) ? 16'(x) : 16'(r);
        return {z, n, h, c, rv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on all three instances; optionally pulses start again while they are busy.
    task automatic run_op(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                          input logic ci, input bit extra_start, input string tag);
        int lat [3];
        int nb [3];
        int nd [3];
        logic [19:0] m;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; carry_in = ci;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        carry_in = 1'($urandom);
        for (int i = 0; i < 3; i++) begin lat[i] = 0; nb[i] = 0; nd[i] = 0; end
        for (int t = 1; t <= 20; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin nd[i]++; lat[i] = t; end
                if (bsy[i]) nb[i]++;
            end
            if (extra_start) start = (t == 1);
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m = model(wid[i], o, va, vb, ci);
            chk($sformatf("%s[%0d].latency", tag, i), lat[i], lat_exp[i]);
            chk($sformatf("%s[%0d].busy_cycles", tag, i), nb[i], lat_exp[i] - 1);
            chk($sformatf("%s[%0d].done_count", tag, i), nd[i], 1);
            chk($sformatf("%s[%0d].result", tag, i), o_res[i], m[15:0]);
            chk($sformatf("%s[%0d].flags", tag, i), o_fl[i], m[19:16]);
        end
    endtask

    initial begin
        logic [19:0] m1;
        logic [19:0] m2;
        int t;
        int ndone;
        nreset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.result", {o_res[0], o_res[1]}, 32'h0);
        chk("reset.result16s", o_res[2], 16'h0);
        chk("reset.flags", {o_fl[0], o_fl[1], o_fl[2]}, 12'h0);
        chk("reset.busy_done", {bsy, dn}, 6'b0);
        nreset = 1'b1;

        run_op(3'd0, 16'h003A, 16'h00C6, 1'b0, 1'b0, "add_3a_c6");
        chk("add_3a_c6.const", {o_fl[0], o_res[0]}, {4'b1011, 16'h0000});
        run_op(3'd3, 16'h003B, 16'h002A, 1'b1, 1'b0, "sbc_3b_2a");
        chk("sbc_3b_2a.const", {o_fl[0], o_res[0]}, {4'b0100, 16'h0010});
        run_op(3'd2, 16'h003E, 16'h003E, 1'b0, 1'b0, "sub_3e_3e");
        run_op(3'd7, 16'h003C, 16'h0040, 1'b0, 1'b0, "cp_3c_40");
        chk("cp_3c_40.const", {o_fl[0], o_res[0]}, {4'b0101, 16'h003C});
        run_op(3'd4, 16'h005A, 16'h003F, 1'b0, 1'b0, "and_5a_3f");
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ffff_1");
        chk("add_ffff_1.const16", {o_fl[1], o_res[1]}, {4'b1011, 16'h0000});
        run_op(3'd1, 16'h1234, 16'h0FCD, 1'b1, 1'b1, "adc_busy_start");

        // Back-to-back on the 8/4 instance: second start lands in its done cycle.
        m1 = model(8, 3'd5, 16'h00A5, 16'h00FF, 1'b0);
        m2 = model(8, 3'd1, 16'h0088, 16'h0077, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 16'h00A5; b = 16'h00FF; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b.first_done", dn[0], 1'b1);
        chk("b2b.first_result", {o_fl[0], o_res[0]}, {m1[19:16], m1[15:0]});
        start = 1'b1; op = 3'd1; a = 16'h0088; b = 16'h0077; carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        t = 1;
        while (!dn[0] && t < 10) begin @(negedge clk); t++; end
        chk("b2b.second_latency", t, 3);
        chk("b2b.second_result", {o_fl[0], o_res[0]}, {m2[19:16], m2[15:0]});
        repeat (20) @(negedge clk);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 16'h000F; b = 16'h0001; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("abort.result", {o_res[0], o_res[1]}, 32'h0);
        chk("abort.result16s", o_res[2], 16'h0);
        chk("abort.flags", {o_fl[0], o_fl[1], o_fl[2]}, 12'h0);
        chk("abort.busy_done", {bsy, dn}, 6'b0);
        @(negedge clk);
        nreset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (dn != 3'b000) ndone++;
            @(negedge clk);
        end
        chk("abort.no_done", ndone, 0);
        run_op(3'd0, 16'h000F, 16'h0001, 1'b0, 1'b0, "after_abort");

        for (int r = 0; r < 8; r++) begin
            run_op(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sm83_alu_serial.md
# sm83_alu_serial

Parametrised, multi-cycle successor to the nibble-slice SM83 ALU. It processes operands of DATA_WIDTH bits one SLICE_WIDTH-bit slice per clock, from least to most significant, with a start/busy/done handshake. It produces a registered result plus SM83 Z/N/H/C flags. It sits beside the CPU datapath, and wider 16-bit ops (e.g. ADD HL,rr) reuse the same slice hardware.

## Interface
Parameters:
- DATA_WIDTH, 8: operand/result width; must be a multiple of SLICE_WIDTH and ≥ 8.
- SLICE_WIDTH, 4: bits processed per cycle; one of 1, 2 or 4.
- Derived NSLICES = DATA_WIDTH/SLICE_WIDTH.

Ports:
- clk, in, 1: single clock, rising edge.
- nreset, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start, in, 1: request; sampled on a rising edge while busy=0.
- op, in, 3: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
- a, in, DATA_WIDTH: operand A.
- b, in, DATA_WIDTH: operand B.
- carry_in, in, 1: C flag input for ADC/SBC.
- result, out, DATA_WIDTH: registered result.
- flag_z, flag_n, flag_h, flag_c, out, 1 each: registered flags.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: capture a, b, op and carry_in into internal registers, clear slice counter, go to RUN. a, b, op and carry_in are don't-care after the capture edge.
- RUN, cycle k (k=0..NSLICES-1): compute slice k with the ripple carry from slice k-1.
  - Slice 0 carry-in: ADD 0; ADC carry_in; SUB/CP 1; SBC !carry_in.
  - B is inverted for SUB/SBC/CP.
  - Logic ops ignore carry.
  - Write the slice into the result shadow register. Latch the carry out of bit 3 as H.
  - At k=NSLICES-1, go to DONE.
- Entering DONE updates result and flags together:
  - result: the shadow register; for CP, result = captured A (unchanged).
  - flag_z = (computed value == 0), including CP.
  - flag_n = 1 for SUB/SBC/CP, 0 otherwise.
  - flag_h: ADD/ADC = carry out of bit 3; SUB/SBC/CP = !carry out of bit 3 (borrow); AND = 1; XOR/OR = 0.
  - flag_c: ADD/ADC = final carry out; SUB/SBC/CP = !final carry (borrow); logic ops = 0.
- DONE lasts one cycle, then returns to IDLE unless start=1, in which case it goes to RUN.
- result and flags hold until the next completion.
- start while busy=1 is ignored; it is neither queued nor corrupting.
- Invalid parameter combinations are an elaboration error.

## Timing
- Reset value of every output: result=0, all flags=0, busy=0, done=0. State is IDLE.
- Asserting nreset mid-RUN aborts immediately. There is no done pulse, and outputs go to their reset values.
- Start accepted at edge T:
  - busy=1 during cycles T+1 .. T+NSLICES.
  - done=1 and the new result/flags are visible during cycle T+NSLICES+1.
  - Latency is NSLICES+1 cycles: 3 for 8/4, 5 for 16/4.
- busy=0 in the DONE cycle, so back-to-back starts give one result every NSLICES+1 cycles.
- Flags and result change only on the edge entering DONE (or on reset).

## Test plan
- 8/4, ADD a=0x3A b=0xC6 -> result 0x00, Z=1 N=0 H=1 C=1; done exactly 3 cycles after start, busy high 2 cycles.
- 8/4, SBC a=0x3B b=0x2A carry_in=1 -> 0x10, Z=0 N=1 H=0 C=0; SUB a=0x3E b=0x3E -> 0x00, Z=1 N=1 H=0 C=0.
- 8/4, CP a=0x3C b=0x40 -> result 0x3C, Z=0 N=1 H=0 C=1; AND a=0x5A b=0x3F -> 0x1A, H=1 C=0 N=0.
- 16/4, ADD a=0xFFFF b=0x0001 -> 0x0000, Z=1 H=1 C=1; done 5 cycles after start. Same op with SLICE_WIDTH=1 -> done 17 cycles after start.
- 8/4: a second start pulsed while busy=1 -> ignored; only one done, result from the first op. A start during the done cycle is accepted; its done follows 3 cycles later.
- nreset asserted during RUN of ADD 0x0F+0x01 -> outputs 0 immediately, no done. After release, the next op completes normally.
